// File: rtl/conv_interleaver_if.sv
// ---------------------------------------------------------------------------
// conv_interleaver_if
// Symbol stream bundle for the convolutional interleaver.
//   in_valid   : in_data is accepted this cycle (no backpressure)
//   in_data    : input symbol, DATA_W bits
//   sync_in    : force the commutator to branch 0 (frame alignment)
//   out_valid  : out_data valid this cycle
//   out_data   : output symbol, DATA_W bits
//   branch_idx : branch that produced the current out_data
// master = symbol source / sink side, slave = the interleaver itself.
// ---------------------------------------------------------------------------
interface conv_interleaver_if #(
  parameter int DATA_W   = 8,
  parameter int BRANCHES = 12
);
  localparam int IDX_W = $clog2(BRANCHES);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              sync_in;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  branch_idx;

  modport master (
    output in_valid, in_data, sync_in,
    input  out_valid, out_data, branch_idx
  );

  modport slave (
    input  in_valid, in_data, sync_in,
    output out_valid, out_data, branch_idx
  );
endinterface

// File: rtl/conv_interleaver.sv
// ---------------------------------------------------------------------------
// conv_interleaver
// Forney convolutional interleaver / deinterleaver. BRANCHES commutated
// branches; branch j delays its symbols by j*UNIT_DEPTH visits (interleave)
// or (BRANCHES-1-j)*UNIT_DEPTH visits (deinterleave). A branch advances only
// when the commutator selects it with an accepted sample.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; clears commutator, outputs and makes
//           every branch read back as all-zero
//   bus   : conv_interleaver_if.slave symbol stream (see interface header)
// Storage is one flat symbol array holding every branch back to back as a
// circular buffer, so it maps onto a single block RAM with registered read.
// ---------------------------------------------------------------------------
module conv_interleaver #(
  parameter int DATA_W       = 8,
  parameter int BRANCHES     = 12,
  parameter int UNIT_DEPTH   = 17,
  parameter int DEINTERLEAVE = 0
) (
  input logic               clk,
  input logic               reset,
  conv_interleaver_if.slave bus
);

  localparam int IDX_W  = $clog2(BRANCHES);
  localparam int MAX_D  = (BRANCHES - 1) * UNIT_DEPTH;
  localparam int PTR_W  = $clog2(MAX_D + 1);
  localparam int TOTAL  = UNIT_DEPTH * BRANCHES * (BRANCHES - 1) / 2;
  localparam int ADDR_W = $clog2(TOTAL + 1);

  function automatic int branch_depth(input int j);
    return (DEINTERLEAVE != 0) ? (BRANCHES - 1 - j) * UNIT_DEPTH : j * UNIT_DEPTH;
  endfunction

  // Start of branch j inside the flat array: sum of the depths before it.
  function automatic int branch_base(input int j);
    int acc;
    acc = 0;
    for (int k = 0; k < j; k++) acc += branch_depth(k);
    return acc;
  endfunction

  logic                accept;
  logic [IDX_W-1:0]    comm_q, comm_d;
  logic [IDX_W-1:0]    sel_b;
  logic [PTR_W-1:0]    ptr_w  [BRANCHES];
  logic [ADDR_W-1:0]   base_w [BRANCHES];
  logic [BRANCHES-1:0] zero_w;
  logic [BRANCHES-1:0] primed_w;
  logic [ADDR_W-1:0]   addr;
  logic                sel_zero;
  logic                sel_primed;

  logic [DATA_W-1:0]   mem_q [TOTAL];
  logic [DATA_W-1:0]   rd_q;
  logic [DATA_W-1:0]   hold_q;
  logic                use_mem_q;
  logic                out_valid_q;
  logic [IDX_W-1:0]    idx_q;

  assign accept = bus.in_valid;

  // sync_in redirects the current sample (if any) to branch 0, so the
  // commutator continues from branch 1 afterwards.
  always_comb begin
    sel_b  = bus.sync_in ? '0 : comm_q;
    comm_d = comm_q;
    if (accept) begin
      comm_d = (sel_b == IDX_W'(BRANCHES - 1)) ? '0 : sel_b + IDX_W'(1);
    end else if (bus.sync_in) begin
      comm_d = '0;
    end
  end

  // Per-branch circular buffer state. The read slot and the write slot are
  // the same entry: the oldest symbol leaves as the newest enters. primed
  // marks that the buffer has wrapped once since reset; before that the
  // slot being read was never written and must read back as zero, which
  // stands in for clearing the RAM on reset.
  for (genvar gi = 0; gi < BRANCHES; gi++) begin : g_branch
    localparam int D = branch_depth(gi);

    assign base_w[gi] = ADDR_W'(branch_base(gi));
    assign zero_w[gi] = (D == 0);

    if (D == 0) begin : g_pass
      assign ptr_w[gi]    = '0;
      assign primed_w[gi] = 1'b1;
    end else begin : g_fifo
      logic [PTR_W-1:0] ptr_q;
      logic             primed_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          ptr_q    <= '0;
          primed_q <= 1'b0;
        end else if (accept && sel_b == IDX_W'(gi)) begin
          if (ptr_q == PTR_W'(D - 1)) begin
            ptr_q    <= '0;
            primed_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + PTR_W'(1);
          end
        end
      end

      assign ptr_w[gi]    = ptr_q;
      assign primed_w[gi] = primed_q;
    end
  end

  assign addr       = base_w[sel_b] + ADDR_W'(ptr_w[sel_b]);
  assign sel_zero   = zero_w[sel_b];
  assign sel_primed = primed_w[sel_b];

  // Read-first RAM: rd_q captures the old entry while the new symbol is
  // written to the same address on the same edge.
  always_ff @(posedge clk) begin
    if (accept && !sel_zero) begin
      mem_q[addr] <= bus.in_data;
      rd_q        <= mem_q[addr];
    end
  end

  // Output side. The final mux only chooses between registered values, so
  // out_data still changes exactly one edge after the accepting edge and
  // holds while out_valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      comm_q      <= '0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      hold_q      <= '0;
      use_mem_q   <= 1'b0;
    end else begin
      comm_q      <= comm_d;
      out_valid_q <= accept;
      if (accept) begin
        idx_q     <= sel_b;
        use_mem_q <= !sel_zero && sel_primed;
        hold_q    <= sel_zero ? bus.in_data : '0;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = use_mem_q ? rd_q : hold_q;
  assign bus.branch_idx = idx_q;

endmodule

// File: tb/tb_conv_interleaver.sv
// ---------------------------------------------------------------------------
// tb_conv_interleaver
// Bench for conv_interleaver. Three configurations are instantiated:
//   dut_a : BRANCHES=3, UNIT_DEPTH=2, interleave
//   dut_c : BRANCHES=3, UNIT_DEPTH=2, deinterleave, fed by dut_a's output
//   dut_d : default 12 branches x 17, interleave
// The reference model keeps, per branch, the list of symbols pushed since
// reset; a visit to a branch of depth D returns the symbol pushed D visits
// earlier on that branch, or 0 if there is none.
// ---------------------------------------------------------------------------
module tb_conv_interleaver;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_d;

  always #5 clk = ~clk;

  conv_interleaver_if #(.DATA_W(8), .BRANCHES(3))  ifa ();
  conv_interleaver_if #(.DATA_W(8), .BRANCHES(3))  ifc ();
  conv_interleaver_if #(.DATA_W(8), .BRANCHES(12)) ifd ();

  conv_interleaver #(.DATA_W(8), .BRANCHES(3), .UNIT_DEPTH(2), .DEINTERLEAVE(0))
    dut_a (.clk(clk), .reset(rst_a), .bus(ifa.slave));
  conv_interleaver #(.DATA_W(8), .BRANCHES(3), .UNIT_DEPTH(2), .DEINTERLEAVE(1))
    dut_c (.clk(clk), .reset(rst_a), .bus(ifc.slave));
  conv_interleaver #(.DATA_W(8), .BRANCHES(12), .UNIT_DEPTH(17), .DEINTERLEAVE(0))
    dut_d (.clk(clk), .reset(rst_d), .bus(ifd.slave));

  // Cascade: deinterleaver directly consumes the interleaver output.
  assign ifc.in_valid = ifa.out_valid;
  assign ifc.in_data  = ifa.out_data;
  assign ifc.sync_in  = 1'b0;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  int         m_nb, m_ud, m_di, m_c;
  int         m_vis [12];
  logic [7:0] m_hist [12][512];
  logic       m_ov;
  logic [7:0] m_od;
  int         m_oi;

  task automatic model_reset(input int nb, input int ud, input int di);
    m_nb = nb; m_ud = ud; m_di = di; m_c = 0;
    for (int i = 0; i < 12; i++) m_vis[i] = 0;
    m_ov = 1'b0; m_od = 8'h00; m_oi = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic s);
    int b, dep;
    if (v) begin
      b   = s ? 0 : m_c;
      dep = (m_di != 0) ? (m_nb - 1 - b) * m_ud : b * m_ud;
      if (dep == 0)              m_od = d;
      else if (m_vis[b] >= dep)  m_od = m_hist[b][m_vis[b] - dep];
      else                       m_od = 8'h00;
      m_hist[b][m_vis[b]] = d;
      m_vis[b]++;
      m_c  = (b + 1) % m_nb;
      m_ov = 1'b1;
      m_oi = b;
    end else begin
      m_ov = 1'b0;
      if (s) m_c = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- bookkeeping ----------------
  int         edge_n = 0;
  int         acc_n, casc_k, li;
  logic [7:0] acc_hist [64];
  int         acc_edge [64];
  logic       casc_en;
  logic       seq_en;
  logic [7:0] exp_seq [18] = '{8'd1, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0, 8'd7, 8'd2, 8'd0,
                                8'd10, 8'd5, 8'd0, 8'd13, 8'd8, 8'd3, 8'd16, 8'd11, 8'd6};
  int         d_samples;
  int         first11;

  task automatic step_a(input logic v, input logic [7:0] d, input logic s);
    logic [7:0] ce;
    ifa.in_valid = v; ifa.in_data = d; ifa.sync_in = s;
    @(posedge clk); #1;
    edge_n++;
    model_step(v, d, s);
    if (v && acc_n < 64) begin
      acc_hist[acc_n] = d;
      acc_edge[acc_n] = edge_n;
      acc_n++;
    end
    chk("a_valid", 32'(ifa.out_valid), 32'(m_ov));
    chk("a_data",  32'(ifa.out_data),  32'(m_od));
    chk("a_idx",   32'(ifa.branch_idx), 32'(m_oi));
    if (seq_en && ifa.out_valid && li < 18) begin
      chk("seq_data", 32'(ifa.out_data), 32'(exp_seq[li]));
      chk("seq_idx",  32'(ifa.branch_idx), 32'(li % 3));
      li++;
    end
    if (casc_en && ifc.out_valid && casc_k < acc_n) begin
      ce = (casc_k >= 12) ? acc_hist[casc_k - 12] : 8'h00;
      chk("casc_data", 32'(ifc.out_data), 32'(ce));
      // Edges from the accepting edge to the visible output, inclusive.
      chk("casc_lat", 32'(edge_n - acc_edge[casc_k] + 1), 32'd2);
      casc_k++;
    end
    ifa.in_valid = 1'b0; ifa.sync_in = 1'b0;
  endtask

  task automatic reset_a();
    ifa.in_valid = 1'b0; ifa.in_data = 8'h00; ifa.sync_in = 1'b0;
    rst_a = 1'b1;
    @(posedge clk); #1;
    edge_n++;
    rst_a = 1'b0;
    model_reset(3, 2, 0);
    acc_n = 0; casc_k = 0; li = 0;
    chk("rst_a_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_a_data",  32'(ifa.out_data),  32'd0);
    chk("rst_a_idx",   32'(ifa.branch_idx), 32'd0);
    chk("rst_c_valid", 32'(ifc.out_valid), 32'd0);
  endtask

  task automatic step_d(input logic v, input logic [7:0] d);
    ifd.in_valid = v; ifd.in_data = d; ifd.sync_in = 1'b0;
    @(posedge clk); #1;
    edge_n++;
    model_step(v, d, 1'b0);
    chk("d_valid", 32'(ifd.out_valid), 32'(m_ov));
    chk("d_data",  32'(ifd.out_data),  32'(m_od));
    chk("d_idx",   32'(ifd.branch_idx), 32'(m_oi));
    if (v) begin
      if (ifd.out_valid && ifd.branch_idx == 4'd11 && ifd.out_data != 8'h00 && first11 < 0)
        first11 = d_samples;
      d_samples++;
    end
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_data = 8'h00; ifa.sync_in = 1'b0;
    ifd.in_valid = 1'b0; ifd.in_data = 8'h00; ifd.sync_in = 1'b0;
    rst_a = 1'b0; rst_d = 1'b1;
    casc_en = 1'b1; seq_en = 1'b1;

    // Continuous 1,2,3,... with the cascade watched throughout.
    reset_a();
    for (int i = 1; i <= 30; i++) step_a(1'b1, 8'(i), 1'b0);
    step_a(1'b0, 8'h00, 1'b0);
    step_a(1'b0, 8'h00, 1'b0);
    chk("casc_count", 32'(casc_k), 32'd30);

    // Alternating valid: same sequence on valid cycles, garbage on gaps.
    reset_a();
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) step_a(1'b1, 8'(i / 2 + 1), 1'b0);
      else            step_a(1'b0, 8'($urandom_range(0, 255)), 1'b0);
    end

    // sync_in behaviour; the cascade is not aligned here.
    casc_en = 1'b0; seq_en = 1'b0;
    reset_a();
    step_a(1'b1, 8'h11, 1'b0);
    step_a(1'b1, 8'h22, 1'b0);             // commutator now at 2
    step_a(1'b0, 8'h00, 1'b1);             // sync without data
    step_a(1'b1, 8'h33, 1'b0);
    chk("sync_idle_idx", 32'(ifa.branch_idx), 32'd0);
    step_a(1'b1, 8'h44, 1'b1);             // commutator was 1
    chk("sync_data_idx", 32'(ifa.branch_idx), 32'd0);
    step_a(1'b1, 8'h55, 1'b0);
    chk("sync_next_idx", 32'(ifa.branch_idx), 32'd1);
    for (int i = 0; i < 40; i++)
      step_a(1'($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 5) == 0));

    // Reset mid-stream, then the first scenario must repeat exactly.
    casc_en = 1'b1; seq_en = 1'b0;
    reset_a();
    for (int i = 1; i <= 20; i++) step_a(1'b1, 8'($urandom_range(1, 255)), 1'b0);
    seq_en = 1'b1;
    reset_a();
    for (int i = 1; i <= 18; i++) step_a(1'b1, 8'(i), 1'b0);
    chk("seq_count", 32'(li), 32'd18);

    // Default configuration, random data and random gaps.
    casc_en = 1'b0; seq_en = 1'b0;
    @(posedge clk); #1;
    rst_d = 1'b0;
    edge_n++;
    model_reset(12, 17, 0);
    chk("rst_d_valid", 32'(ifd.out_valid), 32'd0);
    chk("rst_d_data",  32'(ifd.out_data),  32'd0);
    d_samples = 0; first11 = -1;
    while (d_samples < 3000) begin
      if ($urandom_range(0, 6) == 0) step_d(1'b0, 8'($urandom_range(0, 255)));
      else                           step_d(1'b1, 8'($urandom_range(1, 255)));
    end
    chk("b11_first_nonzero", 32'(first11), 32'd2255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
